// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, hex segment table, sizing helper.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low g..a patterns, entry n at bits [7n+6:7n].
  localparam logic [16*7-1:0] SEG_HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    PHASE_LIT  = 1'b0,
    PHASE_DARK = 1'b1
  } blink_phase_e;

  function automatic int unsigned clog2(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex7seg_dec.sv
// Combinational hex nibble to active-low g..a segment decoder.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_HEX_TABLE[nib*7 +: 7];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned loads and leading-zero blanking.
// Optional blinking of masked digits when SEG_BLINK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int unsigned IW = clog2(DIGITS);
  localparam int unsigned PW = clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
    $error("seg_scan_driver: DIGITS must be 1..16");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_driver: BLINK_FRAMES must be >= 1");
  end

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow_data;
  logic [4*DIGITS-1:0]   disp_data;
  logic [DIGITS-1:0]     shadow_dp;
  logic [DIGITS-1:0]     disp_dp;
  logic                  pending;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [DIGITS-1:0]     lz;
  logic                  zero_run;
  logic                  dark;

  assign slot_end   = (presc == PRESC_LAST);
  assign wrap       = slot_end && (idx == IDX_LAST);
  assign frame_tick = wrap;
  assign nib        = disp_data[{idx, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nib   (nib),
    .seg_n (dec_seg)
  );

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never qualifies.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
      lz[i]    = zero_run;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned FW = clog2(BLINK_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  blink_phase_e  blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= PHASE_LIT;
    end else if (wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= (blink_phase == PHASE_LIT) ? PHASE_DARK : PHASE_LIT;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign dark = (blink_phase == PHASE_DARK) && blink_mask[idx];
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
      an_n        <= '1;
    end else begin
      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // Commit reads the pre-edge shadow, so a load coinciding with the boundary waits one frame.
      if (wrap && pending) begin
        disp_data <= shadow_data;
        disp_dp   <= shadow_dp;
      end
      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp_in;
        pending     <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end

      seg_n <= (dark || (blank_lz && lz[idx])) ? SEG_BLANK : dec_seg;
      dp_n  <= ~(disp_dp[idx] && !dark);
      an_n  <= (presc == '0) ? '1 : ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4): vector table, hand sequences, random run vs model.
module tb_seg_scan_driver;

  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = ND * SD;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state: cycles since reset release plus the load/commit bookkeeping.
  int unsigned m_t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] segs;
    logic [3:0]  dpn;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS       (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_expect(output logic [3:0] an, output logic [6:0] seg, output logic dp);
    int unsigned pos = m_t % SD;
    int unsigned d   = (m_t / SD) % ND;
    int          hi  = -1;
    logic        dk  = 1'b0;
    for (int i = 0; i < int'(ND); i++)
      if (m_disp[4*i +: 4] != 4'h0) hi = i;
`ifdef SEG_BLINK_EN
    dk = blink_mask[d] && (((m_t / FRAME) / BF) % 2 == 1);
`endif
    an  = (pos == 0) ? 4'hF : ~(4'b0001 << d);
    seg = (dk || (blank_lz && d > 0 && int'(d) > hi)) ? 7'h7F : HEX_SEG[m_disp[4*d +: 4]];
    dp  = dk ? 1'b1 : ~m_ddp[d];
  endfunction

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    bit         boundary;
    model_expect(e_an, e_seg, e_dp);
    boundary = (m_t % FRAME == FRAME - 1);
    chk("frame_tick", frame_tick, boundary);
    @(posedge clk); #1;
    if (boundary && m_pend) begin
      m_disp = m_shadow;
      m_ddp  = m_sdp;
    end
    if (load) begin
      m_shadow = data;
      m_sdp    = dp_in;
      m_pend   = 1'b1;
    end else if (boundary) begin
      m_pend = 1'b0;
    end
    m_t++;
    chk("an_n", an_n, e_an);
    if (e_an != 4'hF) begin
      chk("seg_n", seg_n, e_seg);
      chk("dp_n", dp_n, e_dp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    m_t      = 0;
    m_shadow = '0;
    m_disp   = '0;
    m_sdp    = '0;
    m_ddp    = '0;
    m_pend   = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data  = d;
    dp_in = dp;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic align();
    while (m_t % FRAME != 0) step();
  endtask

  // Scans one whole frame from its start, checking lit patterns against fixed constants.
  task automatic expect_frame(input string name, input logic [27:0] segs, input logic [3:0] dpn);
    int unsigned lit [4] = '{0, 0, 0, 0};
    logic [3:0]  sel;
    align();
    for (int unsigned k = 0; k < FRAME; k++) begin
      step();
      for (int unsigned d = 0; d < ND; d++) begin
        sel = 4'b0001 << d;
        if (an_n == ~sel) begin
          lit[d]++;
          chk({name, "_seg"}, seg_n, segs[7*d +: 7]);
          chk({name, "_dp"}, dp_n, dpn[d]);
        end
      end
    end
    for (int unsigned d = 0; d < ND; d++) chk({name, "_lit"}, lit[d], 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0000, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[2] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[4] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
    vecs[5] = '{16'h1234, 4'b0010, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101};
    vecs[6] = '{16'h0F00, 4'b1000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b0111};
    vecs[7] = '{16'h8E60, 4'b0101, 1'b1, {7'h00, 7'h06, 7'h02, 7'h40}, 4'b1010};

    @(posedge clk); #1;
    do_reset();
    repeat (6) step();
    do_reset();
    repeat (SD) step();

    foreach (vecs[i]) begin
      align();
      blank_lz = vecs[i].blz;
      do_load(vecs[i].data, vecs[i].dp);
      expect_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].dpn);
    end

    blank_lz = 1'b0;
    align();
    do_load(16'h1234, 4'b0000);
    expect_frame("tear_base", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    repeat (5) step();
    do_load(16'hABCD, 4'b0000);
    while (m_t % FRAME != 0) begin
      step();
      if (an_n == 4'b1011) chk("tear_d2", seg_n, 7'h24);
      if (an_n == 4'b0111) chk("tear_d3", seg_n, 7'h79);
    end
    expect_frame("tear_next", {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111);

    align();
    do_load(16'h1234, 4'b0010);
    while (m_t % FRAME != FRAME - 1) step();
    chk("coll_tick", frame_tick, 1'b1);
    do_load(16'h8E60, 4'b0000);
    expect_frame("coll_first", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101);
    expect_frame("coll_second", {7'h00, 7'h06, 7'h02, 7'h40}, 4'b1111);

    do_reset();
    for (int unsigned c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) blank_lz = $urandom_range(0, 1) == 1;
`ifdef SEG_BLINK_EN
      if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
`endif
      if ($urandom_range(0, 7) == 0) begin
        for (int unsigned n = 0; n < ND; n++)
          data[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        dp_in = 4'($urandom);
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      step();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
